// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM encoding and frame constants.
package uart_pkg;

   localparam int unsigned DATA_W     = 8;
   localparam int unsigned FRAME_BITS = 10;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StPop   = 3'd1,
      StLoad  = 3'd2,
      StStart = 3'd3,
      StData  = 3'd4,
      StStop  = 3'd5
   } state_t;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between the upstream synchronous FIFO and the UART transmitter.
interface fifo_uart_tx_if;

   logic                           fifo_empty;
   logic                           fifo_re;
   logic [uart_pkg::DATA_W-1:0]    fifo_data;

   // master: the transmitter pulling characters; slave: the FIFO supplying them
   modport master (input fifo_empty, input fifo_data, output fifo_re);
   modport slave  (output fifo_empty, output fifo_data, input fifo_re);

endinterface

// File: rtl/uart_baud_gen.sv
// Bit timer: counts 0..CLKS_PER_BIT-1 and ticks on the terminal count; clear restarts at 0.
module uart_baud_gen #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;

   assign tick = (cnt_q == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (clear || tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that pops characters from an upstream synchronous FIFO one at a time.
module fifo_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned DATA_W       = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   fifo_uart_tx_if.master        fifo,
   output logic                  tx,
   output logic                  busy,
   output logic                  frame_done
);

   import uart_pkg::*;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [2:0]          idx_q, idx_d;
   logic                tx_q, tx_d;
   logic                re_q, re_d;
   logic                tick;
   logic                clear;

   uart_baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .tick  (tick)
   );

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      case (state_q)
         StIdle:  if (!fifo.fifo_empty) state_d = StPop;
         StPop:   state_d = StLoad;
         StLoad: begin
            shift_d = fifo.fifo_data;
            state_d = StStart;
         end
         StStart: if (tick) state_d = StData;
         StData: begin
            if (tick) begin
               shift_d = shift_q >> 1;
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = StStop;
            end
         end
         StStop:  if (tick) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Timer restarts on every state entry so each state gets whole bit periods.
   assign clear = (state_d != state_q);

   // fifo_re is registered from the next state so it is high exactly during POP.
   assign re_d = (state_d == StPop);

   // tx is registered from the current state: the line lags the FSM by one cycle.
   always_comb begin
      tx_d = 1'b1;
      case (state_q)
         StStart: tx_d = 1'b0;
         StData:  tx_d = shift_q[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         shift_q <= '0;
         idx_q   <= '0;
         tx_q    <= 1'b1;
         re_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         tx_q    <= tx_d;
         re_q    <= re_d;
      end
   end

   assign fifo.fifo_re = re_q;
   assign tx           = tx_q;
   assign busy         = (state_q != StIdle);
   assign frame_done   = (state_q == StStop) && tick;

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit; legal range 2..65535.
REQ-002 Parameter DATA_W, default 8, meaning bits per serial character, fixed at 8.
REQ-003 clk  input  1  system clock; all logic samples on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 fifo_empty  input  1  empty flag from the upstream 16x8 synchronous FIFO.
REQ-006 fifo_data  input  8  FIFO read data; valid on the first clock edge after the edge that sampled fifo_re=1 with fifo_empty=0.
REQ-007 fifo_re  output  1  FIFO read strobe; registered; high for exactly one cycle per character.
REQ-008 tx  output  1  serial line in 8N1 format (idle high, start 0, 8 data bits LSB first, 1 stop bit).
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 frame_done  output  1  one-cycle pulse in the last cycle of each stop bit.

Function
REQ-011 The FSM SHALL have the states IDLE, POP, LOAD, START, DATA and STOP.
REQ-012 In IDLE with fifo_empty=0 sampled, the FSM SHALL go to POP; with fifo_empty=1 it SHALL stay in IDLE.
REQ-013 POP SHALL last 1 cycle with fifo_re=1, then go to LOAD; fifo_re SHALL be 0 in every other state.
REQ-014 LOAD SHALL last 1 cycle, capture fifo_data into an 8-bit shift register, then go to START.
REQ-015 START SHALL drive tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-016 DATA SHALL drive shift[0] for CLKS_PER_BIT cycles per bit, shift right after each bit, and count 8 bits with a 3-bit index; after index 7 it SHALL go to STOP.
REQ-017 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, pulse frame_done in its final cycle, then return to IDLE.
REQ-018 IDLE SHALL always occupy at least 1 cycle between frames, so the frame-to-frame period is 10*CLKS_PER_BIT+3 cycles when the FIFO is continuously non-empty.
REQ-019 The first tx low SHALL appear 3 cycles after the edge that first samples fifo_empty=0 in IDLE.
REQ-020 The bit-timer SHALL count from 0 to CLKS_PER_BIT-1, wrap to 0, and produce a tick on the terminal count; it SHALL be cleared on every state entry.
REQ-021 fifo_empty SHALL be ignored outside IDLE; a character in progress SHALL never be aborted by FIFO state changes.
REQ-022 fifo_data SHALL be sampled only in LOAD; the tx output SHALL be registered and glitch-free.

Reset
REQ-023 Asserting reset at any time SHALL force state=IDLE, tx=1, fifo_re=0, busy=0, frame_done=0, shift register=0, bit index=0 and bit-timer=0.
REQ-024 A reset mid-frame SHALL abandon the frame immediately (tx=1 asynchronously), with no FIFO read issued for that character.
REQ-025 After reset deasserts, the first fifo_re SHALL occur no earlier than 1 cycle after the first sampled fifo_empty=0.

Structure
REQ-026 A shared package uart_pkg SHALL hold the FSM state encoding (3-bit), DATA_W=8 and the frame length constant FRAME_BITS=10.
REQ-027 The bit-timer SHALL be a sub-module uart_baud_gen (inputs clk, reset, clear; output tick; parameter CLKS_PER_BIT).
REQ-028 The upstream FIFO SHALL connect directly: fifo_re to the FIFO re input, FIFO empty to fifo_empty, and FIFO data_out to fifo_data.

Verification (CLKS_PER_BIT=4)
REQ-029 Single byte 0xA5 written to the FIFO SHALL give one fifo_re pulse and tx bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles long, with frame_done once.
REQ-030 Writing 0x00, 0xFF and 0x3C back-to-back SHALL produce three frames in order, a 43-cycle frame period, and exactly three fifo_re pulses, with the FIFO empty afterwards.
REQ-031 With the FIFO held empty for 100 cycles, tx SHALL stay 1, and fifo_re and busy SHALL stay 0.
REQ-032 Reset asserted during data bit 3 of 0x81 SHALL make tx=1 and busy=0 immediately; the next queued byte SHALL then transmit intact.
REQ-033 Sixteen bytes (full FIFO) SHALL all be sent in write order, with no fifo_re pulse issued while fifo_empty=1.
REQ-034 Random bytes with random write gaps SHALL give a scoreboard match of tx-decoded data against the write order over 1000 bytes.
